// File: rtl/msrh_fpu_issue_sched.sv
// FPU issue scheduler: buffers dispatched FP ops, tracks operand readiness via
// early wakeup, issues the oldest ready entry, and frees it on the EX3 done report.
module msrh_fpu_issue_sched #(
  parameter int ENTRY_SIZE = 8,
  parameter int PAYLOAD_W  = 64,
  parameter int RNID_W     = 7,
  parameter int WK_NUM     = 4
) (
  input  logic                               i_clk,
  input  logic                               i_reset_n,
  input  logic                               i_disp_valid,
  output logic                               o_disp_ready,
  input  logic [PAYLOAD_W-1:0]               i_disp_payload,
  input  logic [2:0]                         i_disp_src_valid,
  input  logic [2:0]                         i_disp_src_typ,
  input  logic [3*RNID_W-1:0]                i_disp_src_rnid,
  input  logic [2:0]                         i_disp_src_ready,
  input  logic [WK_NUM-1:0]                  i_wk_valid,
  input  logic [WK_NUM-1:0]                  i_wk_typ,
  input  logic [WK_NUM*RNID_W-1:0]           i_wk_rnid,
  output logic                               o_issue_valid,
  output logic [PAYLOAD_W-1:0]               o_issue_payload,
  output logic [ENTRY_SIZE-1:0]              o_issue_index,
  input  logic                               i_done_valid,
  input  logic [ENTRY_SIZE-1:0]              i_done_index,
  input  logic                               i_flush,
  output logic [$clog2(ENTRY_SIZE+1)-1:0]    o_free_count
);

  localparam int CNT_W = $clog2(ENTRY_SIZE+1);

  // Handshake: a dispatch transfers on a rising i_clk when i_disp_valid and
  // o_disp_ready are both high and i_flush is low; the producer holds
  // i_disp_valid and its payload stable until that transfer happens.

  typedef enum logic [1:0] {
    ST_FREE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ISSUED = 2'd2
  } ent_state_e;

  // age[j] set means entry j is older than this entry.
  typedef struct packed {
    ent_state_e              state;
    logic [PAYLOAD_W-1:0]    payload;
    logic [2:0]              src_valid;
    logic [2:0]              src_typ;
    logic [3*RNID_W-1:0]     src_rnid;
    logic [2:0]              src_ready;
    logic [ENTRY_SIZE-1:0]   age;
  } entry_t;

  entry_t ent_q [ENTRY_SIZE];
  entry_t ent_d [ENTRY_SIZE];

  logic [ENTRY_SIZE-1:0] free_vec;
  logic [ENTRY_SIZE-1:0] busy_vec;
  logic [ENTRY_SIZE-1:0] cand;
  logic [ENTRY_SIZE-1:0] winner;
  logic [ENTRY_SIZE-1:0] alloc_oh;
  logic [ENTRY_SIZE-1:0] done_free;
  logic [2:0]            disp_hit;
  logic [2:0]            ent_hit [ENTRY_SIZE];
  logic [CNT_W-1:0]      free_cnt;
  logic                  alloc_found;
  logic                  disp_fire;

  always_comb begin
    free_vec    = '0;
    busy_vec    = '0;
    cand        = '0;
    done_free   = '0;
    alloc_oh    = '0;
    alloc_found = 1'b0;
    free_cnt    = '0;
    for (int i = 0; i < ENTRY_SIZE; i++) begin
      free_vec[i]  = (ent_q[i].state == ST_FREE);
      busy_vec[i]  = (ent_q[i].state != ST_FREE);
      cand[i]      = (ent_q[i].state == ST_WAIT) && (&ent_q[i].src_ready);
      done_free[i] = i_done_valid && i_done_index[i] && (ent_q[i].state == ST_ISSUED);
      free_cnt     = free_cnt + CNT_W'(free_vec[i]);
      if (free_vec[i] && !alloc_found) begin
        alloc_oh[i] = 1'b1;
        alloc_found = 1'b1;
      end
    end
  end

  // Age rows form a total order over live entries, so exactly one candidate wins.
  always_comb begin
    winner = '0;
    for (int i = 0; i < ENTRY_SIZE; i++) begin
      winner[i] = cand[i] && ((cand & ent_q[i].age) == '0);
    end
  end

  always_comb begin
    disp_hit = '0;
    for (int i = 0; i < ENTRY_SIZE; i++) ent_hit[i] = '0;
    for (int k = 0; k < 3; k++) begin
      for (int w = 0; w < WK_NUM; w++) begin
        if (i_wk_valid[w] && (i_wk_typ[w] == i_disp_src_typ[k]) &&
            (i_wk_rnid[w*RNID_W +: RNID_W] == i_disp_src_rnid[k*RNID_W +: RNID_W]))
          disp_hit[k] = 1'b1;
        for (int i = 0; i < ENTRY_SIZE; i++) begin
          if (i_wk_valid[w] && (i_wk_typ[w] == ent_q[i].src_typ[k]) &&
              (i_wk_rnid[w*RNID_W +: RNID_W] == ent_q[i].src_rnid[k*RNID_W +: RNID_W]))
            ent_hit[i][k] = 1'b1;
        end
      end
    end
  end

  assign o_disp_ready = (free_cnt != '0);
  assign o_free_count = free_cnt;
  assign disp_fire    = i_disp_valid && o_disp_ready && !i_flush;

  always_comb begin
    for (int i = 0; i < ENTRY_SIZE; i++) begin
      ent_d[i] = ent_q[i];
      if (i_flush) begin
        ent_d[i].state = ST_FREE;
        ent_d[i].age   = '0;
      end else begin
        ent_d[i].age = ent_q[i].age & ~done_free;
        if (done_free[i]) begin
          ent_d[i].state = ST_FREE;
        end else if (winner[i]) begin
          ent_d[i].state = ST_ISSUED;
        end else if (disp_fire && alloc_oh[i]) begin
          ent_d[i].state     = ST_WAIT;
          ent_d[i].payload   = i_disp_payload;
          ent_d[i].src_valid = i_disp_src_valid;
          ent_d[i].src_typ   = i_disp_src_typ;
          ent_d[i].src_rnid  = i_disp_src_rnid;
          ent_d[i].src_ready = ~i_disp_src_valid | i_disp_src_ready | disp_hit;
          ent_d[i].age       = busy_vec & ~done_free;
        end
        if (ent_q[i].state == ST_WAIT) begin
          ent_d[i].src_ready = ent_q[i].src_ready | ent_hit[i];
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < ENTRY_SIZE; i++) ent_q[i] <= '0;
    end else begin
      for (int i = 0; i < ENTRY_SIZE; i++) ent_q[i] <= ent_d[i];
    end
  end

  always_comb begin
    o_issue_valid   = |cand;
    o_issue_index   = winner;
    o_issue_payload = '0;
    for (int i = 0; i < ENTRY_SIZE; i++) begin
      if (winner[i]) o_issue_payload = o_issue_payload | ent_q[i].payload;
    end
  end

endmodule

// File: tb/tb_msrh_fpu_issue_sched.sv
// Directed bench for msrh_fpu_issue_sched: a per-cycle vector table plus
// hand-written full/flush sequences, with an issue-order scoreboard.
module tb_msrh_fpu_issue_sched;

  localparam int ES = 8;
  localparam int PW = 64;
  localparam int RW = 7;
  localparam int WN = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              disp_valid;
  logic              disp_ready;
  logic [PW-1:0]     disp_payload;
  logic [2:0]        disp_src_valid, disp_src_typ, disp_src_ready;
  logic [3*RW-1:0]   disp_src_rnid;
  logic [WN-1:0]     wk_valid, wk_typ;
  logic [WN*RW-1:0]  wk_rnid;
  logic              issue_valid;
  logic [PW-1:0]     issue_payload;
  logic [ES-1:0]     issue_index;
  logic              done_valid;
  logic [ES-1:0]     done_index;
  logic              flush;
  logic [3:0]        free_count;

  msrh_fpu_issue_sched #(.ENTRY_SIZE(ES), .PAYLOAD_W(PW), .RNID_W(RW), .WK_NUM(WN)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_disp_valid(disp_valid), .o_disp_ready(disp_ready), .i_disp_payload(disp_payload),
    .i_disp_src_valid(disp_src_valid), .i_disp_src_typ(disp_src_typ),
    .i_disp_src_rnid(disp_src_rnid), .i_disp_src_ready(disp_src_ready),
    .i_wk_valid(wk_valid), .i_wk_typ(wk_typ), .i_wk_rnid(wk_rnid),
    .o_issue_valid(issue_valid), .o_issue_payload(issue_payload), .o_issue_index(issue_index),
    .i_done_valid(done_valid), .i_done_index(done_index), .i_flush(flush),
    .o_free_count(free_count)
  );

  int checks = 0;
  int errors = 0;
  logic [PW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // scoreboard: every issue must match the next expected payload
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (issue_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_issue actual=%0h expected=none", issue_payload);
        end else begin
          logic [PW-1:0] e;
          e = exp_q.pop_front();
          if (issue_payload !== e) begin
            errors++;
            $display("FAIL issue_order actual=%0h expected=%0h", issue_payload, e);
          end
        end
      end
    end
  end

  // driver tasks
  task automatic set_idle();
    disp_valid = 1'b0; disp_payload = '0;
    disp_src_valid = '0; disp_src_typ = '0; disp_src_ready = '0; disp_src_rnid = '0;
    wk_valid = '0; wk_typ = '0; wk_rnid = '0;
    done_valid = 1'b0; done_index = '0; flush = 1'b0;
  endtask

  task automatic set_disp(input logic [PW-1:0] pay, input logic [2:0] sv, input logic [2:0] st,
                          input logic [2:0] sr, input logic [RW-1:0] rn1);
    disp_valid = 1'b1; disp_payload = pay;
    disp_src_valid = sv; disp_src_typ = st; disp_src_ready = sr;
    disp_src_rnid = {{(2*RW){1'b0}}, rn1};
  endtask

  task automatic set_wk(input logic typ, input logic [RW-1:0] rn);
    wk_valid = 4'b0001; wk_typ = {3'b000, typ}; wk_rnid = {{(3*RW){1'b0}}, rn};
  endtask

  task automatic set_done(input logic [ES-1:0] idx);
    done_valid = 1'b1; done_index = idx;
  endtask

  typedef struct {
    string         name;
    logic          dv;
    logic [PW-1:0] pay;
    logic [2:0]    sv, st, sr;
    logic [RW-1:0] rn1;
    logic          wkv, wkt;
    logic [RW-1:0] wkrn;
    logic [ES-1:0] done;
    logic [ES-1:0] e_idx;
    logic [PW-1:0] e_pay;
    logic [3:0]    e_free;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic dv, logic [PW-1:0] pay, logic [2:0] sv,
                              logic [2:0] st, logic [2:0] sr, logic [RW-1:0] rn1,
                              logic wkv, logic wkt, logic [RW-1:0] wkrn, logic [ES-1:0] done,
                              logic [ES-1:0] e_idx, logic [PW-1:0] e_pay, logic [3:0] e_free);
    vec_t v;
    v.name = name; v.dv = dv; v.pay = pay; v.sv = sv; v.st = st; v.sr = sr; v.rn1 = rn1;
    v.wkv = wkv; v.wkt = wkt; v.wkrn = wkrn; v.done = done;
    v.e_idx = e_idx; v.e_pay = e_pay; v.e_free = e_free;
    return v;
  endfunction

  // outputs are functions of registered state only, so checking at the
  // negedge where the next inputs are applied sees the post-edge state
  task automatic check_outs(input string name, input logic [ES-1:0] e_idx,
                            input logic [PW-1:0] e_pay, input logic [3:0] e_free);
    chk({name, ".disp_ready"}, 64'(disp_ready), 64'(e_free != 4'd0));
    chk({name, ".issue_valid"}, 64'(issue_valid), 64'(e_idx != '0));
    chk({name, ".issue_index"}, 64'(issue_index), 64'(e_idx));
    chk({name, ".issue_payload"}, issue_payload, e_pay);
    chk({name, ".free_count"}, 64'(free_count), 64'(e_free));
  endtask

  initial begin
    set_idle();
    // cycle-by-cycle table: inputs driven this cycle, outputs expected this cycle
    vecs.push_back(mk("reset",        0, 64'h0,    3'b000, 3'b000, 3'b000, 7'd0, 0, 0, 7'd0, 8'h00, 8'h00, 64'h0,    4'd8));
    vecs.push_back(mk("t1_disp",      1, 64'h1,    3'b111, 3'b000, 3'b111, 7'd0, 0, 0, 7'd0, 8'h00, 8'h00, 64'h0,    4'd8));
    vecs.push_back(mk("t1_issue",     0, 64'h0,    3'b000, 3'b000, 3'b000, 7'd0, 0, 0, 7'd0, 8'h00, 8'h01, 64'h1,    4'd7));
    vecs.push_back(mk("t1_done",      0, 64'h0,    3'b000, 3'b000, 3'b000, 7'd0, 0, 0, 7'd0, 8'h01, 8'h00, 64'h0,    4'd7));
    vecs.push_back(mk("t1_freed",     0, 64'h0,    3'b000, 3'b000, 3'b000, 7'd0, 0, 0, 7'd0, 8'h00, 8'h00, 64'h0,    4'd8));
    vecs.push_back(mk("t2_dispA",     1, 64'hA,    3'b001, 3'b001, 3'b000, 7'd5, 0, 0, 7'd0, 8'h00, 8'h00, 64'h0,    4'd8));
    vecs.push_back(mk("t2_dispB",     1, 64'hB,    3'b111, 3'b000, 3'b111, 7'd0, 0, 0, 7'd0, 8'h00, 8'h00, 64'h0,    4'd7));
    vecs.push_back(mk("t2_issueB",    0, 64'h0,    3'b000, 3'b000, 3'b000, 7'd0, 0, 0, 7'd0, 8'h00, 8'h02, 64'hB,    4'd6));
    vecs.push_back(mk("t2_wakeA",     0, 64'h0,    3'b000, 3'b000, 3'b000, 7'd0, 1, 1, 7'd5, 8'h00, 8'h00, 64'h0,    4'd6));
    vecs.push_back(mk("t2_issueA",    0, 64'h0,    3'b000, 3'b000, 3'b000, 7'd0, 0, 0, 7'd0, 8'h02, 8'h01, 64'hA,    4'd6));
    vecs.push_back(mk("t2_doneA",     0, 64'h0,    3'b000, 3'b000, 3'b000, 7'd0, 0, 0, 7'd0, 8'h01, 8'h00, 64'h0,    4'd7));
    vecs.push_back(mk("t2_freed",     0, 64'h0,    3'b000, 3'b000, 3'b000, 7'd0, 0, 0, 7'd0, 8'h00, 8'h00, 64'h0,    4'd8));
    vecs.push_back(mk("t3_dispD",     1, 64'hD,    3'b111, 3'b000, 3'b111, 7'd0, 0, 0, 7'd0, 8'h00, 8'h00, 64'h0,    4'd8));
    vecs.push_back(mk("t3_dispY",     1, 64'h5959, 3'b001, 3'b001, 3'b000, 7'd9, 0, 0, 7'd0, 8'h00, 8'h01, 64'hD,    4'd7));
    // GPR wakeup must not wake an FPR source; done on the WAIT entry 1 is ignored
    vecs.push_back(mk("t4_gpr_wake",  0, 64'h0,    3'b000, 3'b000, 3'b000, 7'd0, 1, 0, 7'd9, 8'h03, 8'h00, 64'h0,    4'd6));
    vecs.push_back(mk("t3_dispZ_wkY", 1, 64'h5A,   3'b111, 3'b000, 3'b111, 7'd0, 1, 1, 7'd9, 8'h00, 8'h00, 64'h0,    4'd7));
    vecs.push_back(mk("t3_issueY",    0, 64'h0,    3'b000, 3'b000, 3'b000, 7'd0, 0, 0, 7'd0, 8'h00, 8'h02, 64'h5959, 4'd6));
    vecs.push_back(mk("t3_issueZ",    0, 64'h0,    3'b000, 3'b000, 3'b000, 7'd0, 0, 0, 7'd0, 8'h02, 8'h01, 64'h5A,   4'd6));
    vecs.push_back(mk("t3_doneZ",     0, 64'h0,    3'b000, 3'b000, 3'b000, 7'd0, 0, 0, 7'd0, 8'h01, 8'h00, 64'h0,    4'd7));
    vecs.push_back(mk("t3_freed",     0, 64'h0,    3'b000, 3'b000, 3'b000, 7'd0, 0, 0, 7'd0, 8'h00, 8'h00, 64'h0,    4'd8));

    repeat (3) @(negedge clk);
    chk("reset.free_count", 64'(free_count), 64'd8);
    chk("reset.issue_valid", 64'(issue_valid), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      set_idle();
      if (vecs[i].dv) set_disp(vecs[i].pay, vecs[i].sv, vecs[i].st, vecs[i].sr, vecs[i].rn1);
      if (vecs[i].wkv) set_wk(vecs[i].wkt, vecs[i].wkrn);
      if (vecs[i].done != '0) set_done(vecs[i].done);
      if (vecs[i].e_idx != '0) exp_q.push_back(vecs[i].e_pay);
      check_outs(vecs[i].name, vecs[i].e_idx, vecs[i].e_pay, vecs[i].e_free);
    end

    // fill all 8 entries with ops waiting on FPR rnid 40+i
    for (int i = 0; i < ES; i++) begin
      @(negedge clk);
      set_idle();
      set_disp(64'h100 + 64'(i), 3'b001, 3'b001, 3'b000, 7'(40 + i));
      check_outs($sformatf("full_fill%0d", i), 8'h00, 64'h0, 4'(ES - i));
    end
    @(negedge clk);
    set_idle();
    set_disp(64'h999, 3'b111, 3'b000, 3'b111, 7'd0);
    set_wk(1'b1, 7'd43);
    check_outs("full_held", 8'h00, 64'h0, 4'd0);
    @(negedge clk);
    set_idle();
    set_disp(64'h999, 3'b111, 3'b000, 3'b111, 7'd0);
    exp_q.push_back(64'h103);
    check_outs("full_issue3", 8'h08, 64'h103, 4'd0);
    @(negedge clk);
    set_done(8'h08);
    check_outs("full_done3", 8'h00, 64'h0, 4'd0);
    @(negedge clk);
    done_valid = 1'b0; done_index = '0;
    check_outs("full_slot_free", 8'h00, 64'h0, 4'd1);
    // flush while the 9th op is the candidate: issue stays visible this cycle
    @(negedge clk);
    set_idle();
    flush = 1'b1;
    set_disp(64'hF1, 3'b111, 3'b000, 3'b111, 7'd0);
    exp_q.push_back(64'h999);
    check_outs("flush8_cycle", 8'h08, 64'h999, 4'd0);
    @(negedge clk);
    set_idle();
    check_outs("flush8_after", 8'h00, 64'h0, 4'd8);

    // five live waiting entries, then flush with a ready dispatch
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      set_idle();
      set_disp(64'h200 + 64'(i), 3'b001, 3'b001, 3'b000, 7'(60 + i));
      check_outs($sformatf("live_fill%0d", i), 8'h00, 64'h0, 4'(ES - i));
    end
    @(negedge clk);
    set_idle();
    flush = 1'b1;
    set_disp(64'hEE, 3'b111, 3'b000, 3'b111, 7'd0);
    check_outs("flush5_cycle", 8'h00, 64'h0, 4'd3);
    @(negedge clk);
    set_idle();
    set_wk(1'b1, 7'd60);
    check_outs("flush5_after", 8'h00, 64'h0, 4'd8);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      set_idle();
      check_outs($sformatf("flush5_quiet%0d", i), 8'h00, 64'h0, 4'd8);
    end

    @(negedge clk);
    #2;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
